// File: rtl/mem_copy_engine.sv
// Word-by-word memory copy engine. Each word is read into a buffer in one
// cycle, then written to the destination in the next (ascending, forward copy).
module mem_copy_engine #(
  parameter int LEN_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      src,
  input  logic [31:0]      dst,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] count,
  output logic [31:0]      mem_a,
  output logic             mem_we,
  output logic [31:0]      mem_wd,
  input  logic [31:0]      mem_rd
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      src_q, dst_q, buf_q;
  logic [LEN_W-1:0] len_q, i_q, count_q;
  logic [31:0]      i_off;
  logic             last_word;

  assign i_off     = 32'(i_q) << 2;
  assign last_word = (i_q == (len_q - LEN_W'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      i_q     <= '0;
      count_q <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            src_q   <= src;
            dst_q   <= dst;
            len_q   <= len;
            i_q     <= '0;
            count_q <= '0;
          end
        end
        READ:  buf_q <= mem_rd;
        WRITE: begin
          count_q <= count_q + LEN_W'(1);
          if (!last_word) i_q <= i_q + LEN_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = (len == '0) ? DONE : READ;
      end
      READ:  state_d = WRITE;
      WRITE: state_d = last_word ? DONE : READ;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs depend only on state and registers, so reset clears them at once.
  always_comb begin
    mem_a  = '0;
    mem_we = 1'b0;
    mem_wd = '0;
    busy   = 1'b0;
    done   = 1'b0;
    case (state_q)
      READ: begin
        busy  = 1'b1;
        mem_a = (src_q + i_off) & 32'hFFFF_FFFC;
      end
      WRITE: begin
        busy   = 1'b1;
        mem_we = 1'b1;
        mem_a  = (dst_q + i_off) & 32'hFFFF_FFFC;
        mem_wd = buf_q;
      end
      DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign count = count_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed bench for mem_copy_engine: a 4 KB word memory model, a write
// scoreboard fed by the stimulus and drained by a negedge monitor.
module tb_mem_copy_engine;
  localparam int LEN_W = 12;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [31:0]      src = '0;
  logic [31:0]      dst = '0;
  logic [LEN_W-1:0] len = '0;
  logic             busy, done, mem_we;
  logic [LEN_W-1:0] count;
  logic [31:0]      mem_a, mem_wd, mem_rd;

  logic [31:0] mem [0:1023];
  logic        pk_en = 1'b0;
  logic [9:0]  pk_idx = '0;
  logic [31:0] pk_val = '0;

  logic [63:0] exp_q[$];
  logic [31:0] rd_log[$];
  logic [63:0] mon_e;
  int n_vec = 0;
  int n_fail = 0;
  int n_wr = 0;
  int lat, bc, nw, wr0;

  always #5 clk = ~clk;

  mem_copy_engine #(.LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .src(src), .dst(dst), .len(len),
    .busy(busy), .done(done), .count(count), .mem_a(mem_a), .mem_we(mem_we),
    .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  assign mem_rd = mem[mem_a[11:2]];

  always @(posedge clk) begin
    if (mem_we) mem[mem_a[11:2]] <= mem_wd;
    else if (pk_en) mem[pk_idx] <= pk_val;
  end

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endfunction

  // Monitor: every write must match the next expected {addr, data}.
  always @(negedge clk) begin
    if (mem_we) begin
      n_wr++;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_write: got a=%h d=%h, required no write", mem_a, mem_wd);
      end else begin
        mon_e = exp_q.pop_front();
        chk("write", {mem_a, mem_wd}, mon_e);
      end
    end else if (busy) begin
      rd_log.push_back(mem_a);
    end
  end

  task automatic poke(input int idx, input logic [31:0] v);
    pk_idx = idx[9:0];
    pk_val = v;
    pk_en  = 1'b1;
    @(posedge clk); #1;
    pk_en  = 1'b0;
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  // Edges are counted with the start-sampling edge as edge 1.
  task automatic run_copy(input logic [31:0] s, input logic [31:0] d,
                          input logic [LEN_W-1:0] l, input int restart,
                          output int lat_o, output int bc_o);
    lat_o = 0;
    bc_o  = 0;
    src = s; dst = d; len = l; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      if (busy) bc_o++;
      if (done) begin
        lat_o = c;
        break;
      end
      if (c == restart) begin
        start = 1'b1; src = 32'h0; dst = 32'h380; len = 2;
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
  endtask

  task automatic post_done();
    @(posedge clk); #1;
    chk("done_one_cycle", {63'd0, done}, 64'd0);
    chk("idle_busy", {63'd0, busy}, 64'd0);
    chk("idle_mem_a", {32'd0, mem_a}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before 200000");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_count", {52'd0, count}, 64'd0);
    chk("rst_we", {63'd0, mem_we}, 64'd0);
    chk("rst_mem_a", {32'd0, mem_a}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic copy of four words.
    poke(0, 32'h11); poke(1, 32'h22); poke(2, 32'h33); poke(3, 32'h44);
    push_wr(32'h100, 32'h11); push_wr(32'h104, 32'h22);
    push_wr(32'h108, 32'h33); push_wr(32'h10C, 32'h44);
    run_copy(32'h0, 32'h100, 4, 0, lat, bc);
    chk("basic_latency", 64'(lat), 64'd9);
    chk("basic_busy_cycles", 64'(bc), 64'd8);
    chk("basic_count", {52'd0, count}, 64'd4);
    post_done();
    chk("basic_count_hold", {52'd0, count}, 64'd4);
    chk("basic_mem0", {32'd0, mem[32'h40]}, 64'h11);
    chk("basic_mem3", {32'd0, mem[32'h43]}, 64'h44);
    chk("basic_q_empty", 64'(exp_q.size()), 64'd0);

    // Zero-length request.
    wr0 = n_wr;
    run_copy(32'h40, 32'h800, 0, 0, lat, bc);
    chk("len0_latency", 64'(lat), 64'd1);
    chk("len0_busy_cycles", 64'(bc), 64'd0);
    chk("len0_count", {52'd0, count}, 64'd0);
    post_done();
    chk("len0_no_write", 64'(n_wr - wr0), 64'd0);

    // Overlapping forward copy smears word 0 across the destination.
    poke(0, 32'h1); poke(1, 32'h2); poke(2, 32'h3); poke(3, 32'h0);
    push_wr(32'h4, 32'h1); push_wr(32'h8, 32'h1); push_wr(32'hC, 32'h1);
    run_copy(32'h0, 32'h4, 3, 0, lat, bc);
    chk("ovl_latency", 64'(lat), 64'd7);
    chk("ovl_count", {52'd0, count}, 64'd3);
    post_done();
    chk("ovl_mem1", {32'd0, mem[1]}, 64'h1);
    chk("ovl_mem2", {32'd0, mem[2]}, 64'h1);
    chk("ovl_mem3", {32'd0, mem[3]}, 64'h1);

    // Start while busy and while in DONE must be ignored.
    poke(32'h80, 32'hA0); poke(32'h81, 32'hA1); poke(32'h82, 32'hA2);
    poke(32'hE0, 32'h5A5A_5A5A);
    push_wr(32'h300, 32'hA0); push_wr(32'h304, 32'hA1); push_wr(32'h308, 32'hA2);
    run_copy(32'h200, 32'h300, 3, 3, lat, bc);
    chk("busy_start_latency", 64'(lat), 64'd7);
    chk("busy_start_count", {52'd0, count}, 64'd3);
    src = 32'h0; dst = 32'h380; len = 1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("done_start_busy", {63'd0, busy}, 64'd0);
    chk("done_start_done", {63'd0, done}, 64'd0);
    chk("busy_start_mem2", {32'd0, mem[32'hC2]}, 64'hA2);
    chk("busy_start_alt_dst", {32'd0, mem[32'hE0]}, 64'h5A5A_5A5A);

    // Reset during the third write of a five-word copy.
    for (int k = 0; k < 5; k++) begin
      poke(32'h100 + k, 32'hB0 + 32'(k));
      poke(32'h140 + k, 32'hD0 + 32'(k));
    end
    push_wr(32'h500, 32'hB0); push_wr(32'h504, 32'hB1);
    nw = 0;
    src = 32'h400; dst = 32'h500; len = 5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (mem_we) nw++;
      if (nw == 3) begin
        rst_n = 1'b0;
        #1;
        chk("rst_mid_we", {63'd0, mem_we}, 64'd0);
        chk("rst_mid_busy", {63'd0, busy}, 64'd0);
        chk("rst_mid_count", {52'd0, count}, 64'd0);
        break;
      end
      @(posedge clk); #1;
    end
    chk("rst_reached_write3", 64'(nw), 64'd3);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_busy", {63'd0, busy}, 64'd0);
    chk("rel_done", {63'd0, done}, 64'd0);
    chk("rel_count", {52'd0, count}, 64'd0);
    chk("rst_dst0", {32'd0, mem[32'h140]}, 64'hB0);
    chk("rst_dst1", {32'd0, mem[32'h141]}, 64'hB1);
    chk("rst_dst2_untouched", {32'd0, mem[32'h142]}, 64'hD2);
    chk("rst_q_empty", 64'(exp_q.size()), 64'd0);

    // Address wrap at the top of the 32-bit space.
    poke(32'h3FF, 32'hAAAA_0001); poke(0, 32'hBBBB_0002);
    rd_log.delete();
    push_wr(32'h600, 32'hAAAA_0001); push_wr(32'h604, 32'hBBBB_0002);
    run_copy(32'hFFFF_FFFC, 32'h600, 2, 0, lat, bc);
    chk("wrap_latency", 64'(lat), 64'd5);
    chk("wrap_rd0", {32'd0, (rd_log.size() > 0) ? rd_log.pop_front() : 32'hDEAD_BEEF}, 64'hFFFF_FFFC);
    chk("wrap_rd1", {32'd0, (rd_log.size() > 0) ? rd_log.pop_front() : 32'hDEAD_BEEF}, 64'h0);
    post_done();

    // Misaligned addresses are truncated to the word boundary.
    poke(32'h40, 32'hCAFE_0001);
    rd_log.delete();
    push_wr(32'h700, 32'hCAFE_0001);
    run_copy(32'h103, 32'h702, 1, 0, lat, bc);
    chk("misal_latency", 64'(lat), 64'd3);
    chk("misal_rd0", {32'd0, (rd_log.size() > 0) ? rd_log.pop_front() : 32'hDEAD_BEEF}, 64'h100);
    post_done();
    chk("misal_mem", {32'd0, mem[32'h1C0]}, 64'hCAFE_0001);
    chk("final_q_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_copy_engine.md
MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

Interface
REQ-001 The block SHALL have parameter LEN_W, default 12, giving the width of the word-count fields (max 2^LEN_W-1 words per transfer).
REQ-002 The block SHALL have port clk, input, 1, the single system clock; all state changes on posedge clk.
REQ-003 The block SHALL have port rst_n, input, 1, reset that is asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1, request to begin a copy; sampled only in IDLE.
REQ-005 The block SHALL have port src, input, 32, byte address of the first source word; captured on accepted start.
REQ-006 The block SHALL have port dst, input, 32, byte address of the first destination word; captured on accepted start.
REQ-007 The block SHALL have port len, input, LEN_W, number of 32-bit words to copy; captured on accepted start.
REQ-008 The block SHALL have port busy, output, 1, high in states READ and WRITE.
REQ-009 The block SHALL have port done, output, 1, one-cycle completion pulse.
REQ-010 The block SHALL have port count, output, LEN_W, number of words fully written in the current/last transfer.
REQ-011 The block SHALL have port mem_a, output, 32, byte address to data memory.
REQ-012 The block SHALL have port mem_we, output, 1, write enable to data memory (memory writes on posedge clk when high).
REQ-013 The block SHALL have port mem_wd, output, 32, write data to data memory.
REQ-014 The block SHALL have port mem_rd, input, 32, combinational read data returned by data memory for the current mem_a.

Function
REQ-015 The FSM SHALL have states IDLE, READ, WRITE, DONE; mem_we, mem_a, mem_wd, busy and done SHALL be decoded from state and registers only (no input-to-output paths).
REQ-016 In IDLE with start=1 and len!=0, the next state SHALL be READ, with src/dst/len latched, index i=0 and count=0.
REQ-017 In IDLE with start=1 and len=0, the next state SHALL be DONE with count=0; no memory access SHALL occur.
REQ-018 In READ: mem_a=(src_q+4*i) with bits[1:0] forced to 00, mem_we=0; at the clock edge mem_rd SHALL be captured into a 32-bit data buffer, and the next state SHALL be WRITE.
REQ-019 In WRITE: mem_a=(dst_q+4*i) with bits[1:0]=00, mem_we=1, mem_wd=buffer; at the edge count SHALL increment.
REQ-020 After WRITE, if i==len_q-1 the next state SHALL be DONE; otherwise i SHALL increment and the next state SHALL be READ.
REQ-021 In DONE, done=1 for exactly one cycle, then the state SHALL return to IDLE; count SHALL hold its value until the next accepted start.
REQ-022 In IDLE and DONE: mem_we=0, mem_a=0, mem_wd=0.
REQ-023 Address arithmetic SHALL be modulo 2^32 (wrap from 0xFFFFFFFC to 0x00000000).
REQ-024 Latency SHALL be as follows: for len=N>0, done SHALL be asserted in the cycle 2N+1 edges after the start edge; throughput is 2 cycles per word.
REQ-025 start SHALL be ignored while not in IDLE, including in DONE.
REQ-026 Word order SHALL be ascending; for overlapping regions each word SHALL be read immediately before its own write (forward-copy semantics, no further hazard handling).

Reset
REQ-027 When rst_n=0, the block SHALL asynchronously enter IDLE and clear i, count, buffer, src_q, dst_q and len_q; mem_we, busy and done SHALL go low without waiting for clk.
REQ-028 rst_n asserted during WRITE SHALL drop mem_we before the next posedge, so no partial/extra write occurs; rst_n release SHALL leave the block in IDLE.

Verification
REQ-029 Bench SHALL cover a basic copy: mem[0..3]=0x11,0x22,0x33,0x44; start src=0x0 dst=0x100 len=4 -> mem[0x100..0x10C]=0x11..0x44, done at edge 9 after start, count=4, busy high for 8 cycles.
REQ-030 Bench SHALL cover len=0: start len=0 -> done pulse on the next cycle, mem_we never high, count=0.
REQ-031 Bench SHALL cover an overlapping forward copy: mem[0..2]=1,2,3; src=0x0 dst=0x4 len=3 -> mem[1..3]=1,1,1.
REQ-032 Bench SHALL cover start while busy: a second start with different src during a copy -> ignored, and the first copy result is unchanged.
REQ-033 Bench SHALL cover reset mid-WRITE: rst_n low on the 3rd WRITE of len=5 -> mem_we low immediately, exactly 2 destination words written, and after release busy=0, done=0, count=0.
REQ-034 Bench SHALL cover wrap and misalignment: src=0xFFFFFFFC len=2 -> second read at mem_a=0x00000000; src=0x103 -> mem_a=0x100.
